instr_cache: RTL and testbench

Direct-mapped instruction cache between the instruction-fetch unit and `memory_controller`. Serves 32-bit instructions to the fetcher with 1-cycle hit latency. On a miss it drives the controller's instruction-fetch request port (`instr_signal`/`instr_a` out, `instr_done`/`instr_d` in) and fills an 8-byte line, which holds two instructions. It aborts cleanly on `clear_signal` (misprediction).

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_store.sv | 47 ++++
 rtl/instr_cache.sv | 135 +++++++++++++
 tb/tb_instr_cache.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, state encoding and geometry helpers for the direct-mapped
// instruction cache.
package icache_pkg;

    localparam int LINE_BYTES  = 8;
    localparam int OFFSET_BITS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_e;

    function automatic int tag_bits(input int index_bits);
        return 32 - index_bits - OFFSET_BITS;
    endfunction

    function automatic int line_count(input int index_bits);
        return 1 << index_bits;
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays for the instruction cache: combinational read port,
// synchronous write port, valid bits cleared by reset.
module icache_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [INDEX_BITS-1:0]               rd_index,
    output logic                                rd_valid,
    output logic [tag_bits(INDEX_BITS)-1:0]     rd_tag,
    output logic [63:0]                         rd_data,
    input  logic                                we,
    input  logic [INDEX_BITS-1:0]               wr_index,
    input  logic [tag_bits(INDEX_BITS)-1:0]     wr_tag,
    input  logic [63:0]                         wr_data
);

    localparam int TAG_W = tag_bits(INDEX_BITS);
    localparam int LINES = line_count(INDEX_BITS);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [63:0]      data_q [LINES];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset; they are only trusted behind a valid bit.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 1-cycle hits, 8-byte line fills through the
// memory controller's instruction port, clean abort on misprediction clear.
//
//   state | meaning
//   IDLE  | waiting for a fetch; hits are answered from here
//   MISS  | line fill outstanding, instr_signal/instr_a held stable
module instr_cache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [31:0] if_instr,
    output logic        instr_signal,
    output logic [31:0] instr_a,
    input  logic [63:0] instr_d,
    input  logic        instr_done
);

    localparam int TAG_W   = tag_bits(INDEX_BITS);
    localparam int TAG_LSB = INDEX_BITS + OFFSET_BITS;

    icache_state_e state_q, state_d;
    logic        sig_d;
    logic [31:0] addr_d;
    logic        ready_d;
    logic [31:0] word_d;
    logic        miss_word_q, miss_word_d;
    logic        fill_we, store_we;

    logic [INDEX_BITS-1:0] rd_index, wr_index;
    logic [TAG_W-1:0]      req_tag, wr_tag, line_tag;
    logic                  line_valid;
    logic [63:0]           line_data;
    logic                  hit;
    logic [31:0]           hit_word, fill_word;

    logic unused_pc_bits;
    assign unused_pc_bits = ^if_pc[1:0];

    assign rd_index = if_pc[TAG_LSB-1:OFFSET_BITS];
    assign req_tag  = if_pc[31:TAG_LSB];

    // The latched line address doubles as the fill's index/tag source.
    assign wr_index = instr_a[TAG_LSB-1:OFFSET_BITS];
    assign wr_tag   = instr_a[31:TAG_LSB];

    assign hit       = line_valid && (line_tag == req_tag);
    assign hit_word  = if_pc[2] ? line_data[63:32] : line_data[31:0];
    assign fill_word = miss_word_q ? instr_d[63:32] : instr_d[31:0];
    assign store_we  = fill_we && rdy_in && !rst_in;

    icache_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_index (rd_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (store_we),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (instr_d)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            instr_signal <= 1'b0;
            instr_a      <= '0;
            if_ready     <= 1'b0;
            if_instr     <= '0;
            miss_word_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            instr_signal <= sig_d;
            instr_a      <= addr_d;
            if_ready     <= ready_d;
            if_instr     <= word_d;
            miss_word_q  <= miss_word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sig_d       = instr_signal;
        addr_d      = instr_a;
        ready_d     = 1'b0;
        word_d      = if_instr;
        miss_word_d = miss_word_q;
        fill_we     = 1'b0;

        if (clear_signal) begin
            state_d = IDLE;
            sig_d   = 1'b0;
            // Data arriving with the clear is still correct for instr_a, so keep it.
            fill_we = (state_q == MISS) && instr_done;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req && !if_ready) begin
                        if (hit) begin
                            word_d  = hit_word;
                            ready_d = 1'b1;
                        end else begin
                            addr_d      = {if_pc[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                            sig_d       = 1'b1;
                            miss_word_d = if_pc[2];
                            state_d     = MISS;
                        end
                    end
                end
                MISS: begin
                    if (instr_done) begin
                        fill_we = 1'b1;
                        word_d  = fill_word;
                        ready_d = 1'b1;
                        sig_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: controller/memory model, line-presence
// reference model, per-cycle output monitor, directed and random fetches.
module tb_instr_cache;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_signal, if_req;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        instr_signal;
    logic [31:0] instr_a;
    logic [63:0] instr_d;
    logic        instr_done;

    always #5 clk_in = ~clk_in;

    instr_cache #(.INDEX_BITS(6)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_signal (clear_signal),
        .if_req       (if_req),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .instr_signal (instr_signal),
        .instr_a      (instr_a),
        .instr_d      (instr_d),
        .instr_done   (instr_done)
    );

    // ---------------- memory contents ----------------
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5a;
    endfunction

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [63:0] d;
        logic [31:0] base;
        base = {a[31:3], 3'b000};
        for (int k = 0; k < 8; k++) d[8*k +: 8] = mem_byte(base + k);
        return d;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [63:0] d;
        d = line_of(pc);
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    // ---------------- controller model: accept, 8 byte stages, done ----------------
    logic        mem_busy, mem_done;
    int          mem_cnt;
    logic [63:0] mem_data;
    logic [31:0] mem_addr;
    logic        inj_done = 1'b0;
    logic [63:0] inj_data = '0;

    assign instr_done = mem_done | inj_done;
    assign instr_d    = inj_done ? inj_data : mem_data;

    always @(posedge clk_in) begin
        if (rst_in) begin
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            mem_cnt  <= 0;
            mem_data <= '0;
            mem_addr <= '0;
        end else if (rdy_in) begin
            mem_done <= 1'b0;
            if (mem_busy) begin
                if (!instr_signal) mem_busy <= 1'b0;
                else if (mem_cnt == 0) begin
                    mem_done <= 1'b1;
                    mem_data <= line_of(mem_addr);
                    mem_busy <= 1'b0;
                end else mem_cnt <= mem_cnt - 1;
            end else if (instr_signal && !mem_done) begin
                mem_busy <= 1'b1;
                mem_cnt  <= 8;
                mem_addr <= instr_a;
            end
        end
    end

    // ---------------- reference model: which lines are present ----------------
    logic        ref_valid [64];
    logic [22:0] ref_tag   [64];
    logic        fill_pending;
    logic [31:0] fill_addr;

    function automatic bit ref_hit(input logic [31:0] pc);
        return ref_valid[pc[8:3]] && (ref_tag[pc[8:3]] == pc[31:9]);
    endfunction

    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 64; i++) ref_valid[i] <= 1'b0;
            fill_pending <= 1'b0;
            fill_addr    <= '0;
        end else if (rdy_in) begin
            if (fill_pending && instr_done) begin
                ref_valid[fill_addr[8:3]] <= 1'b1;
                ref_tag[fill_addr[8:3]]   <= fill_addr[31:9];
                fill_pending <= 1'b0;
            end
            if (clear_signal) fill_pending <= 1'b0;
            else if (!fill_pending && if_req && !if_ready && !ref_hit(if_pc)) begin
                fill_pending <= 1'b1;
                fill_addr    <= if_pc;
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    logic        req_live = 1'b0;
    logic [31:0] cur_pc   = '0;
    logic        rdy_edge = 1'b1;
    logic        p_ready, p_sig;
    logic [31:0] p_instr, p_a;
    bit          have_prev = 0;
    int          mchecks = 0, merrors = 0;

    always @(posedge clk_in) rdy_edge <= rdy_in;

    task automatic mchk(input string name, input logic [65:0] act, input logic [65:0] exp);
        mchecks++;
        if (act !== exp) begin
            merrors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (have_prev && !rdy_edge) begin
                mchk("freeze", {if_ready, instr_signal, if_instr, instr_a},
                               {p_ready, p_sig, p_instr, p_a});
            end else begin
                if (if_ready) begin
                    mchk("ready_single_cycle", {65'd0, p_ready}, 66'd0);
                    mchk("ready_expected", {65'd0, req_live}, 66'd1);
                    if (req_live) mchk("ready_word", {34'd0, if_instr}, {34'd0, word_at(cur_pc)});
                end
                if (instr_signal && req_live)
                    mchk("fill_addr", {34'd0, instr_a}, {34'd0, cur_pc[31:3], 3'b000});
            end
        end
        p_ready   = if_ready;
        p_sig     = instr_signal;
        p_instr   = if_instr;
        p_a       = instr_a;
        have_prev = 1;
    end

    // ---------------- driver ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int stall_at,
                            output int lat, output logic [31:0] word, output logic [31:0] addr_seen);
        bit exp_hit, saw_sig;
        int exp_lat;
        exp_hit = ref_hit(pc);
        exp_lat = (exp_hit ? 1 : 12) + ((stall_at >= 0) ? 3 : 0);
        cur_pc = pc; req_live = 1'b1; if_pc = pc; if_req = 1'b1;
        lat = 0; saw_sig = 0; addr_seen = '0; word = '0;
        if (stall_at == 0) rdy_in = 1'b0;
        while (lat < 80) begin
            @(posedge clk_in); lat++;
            @(negedge clk_in);
            if (instr_signal && !saw_sig) begin saw_sig = 1; addr_seen = instr_a; end
            if (if_ready) break;
            if (stall_at >= 0 && lat == stall_at) rdy_in = 1'b0;
            if (stall_at >= 0 && lat == stall_at + 3) rdy_in = 1'b1;
        end
        word = if_instr;
        if_req = 1'b0; rdy_in = 1'b1;
        chk("fetch_latency", 64'(lat), 64'(exp_lat));
        chk("fetch_word", {32'd0, word}, {32'd0, word_at(pc)});
        chk("fetch_fill_req", {63'd0, saw_sig}, {63'd0, !exp_hit});
        @(posedge clk_in); @(negedge clk_in);
        chk("ready_dropped", {63'd0, if_ready}, 64'd0);
        req_live = 1'b0;
    endtask

    task automatic fetch_clear(input logic [31:0] pc, input int clr_at);
        bit seen_ready;
        cur_pc = pc; req_live = 1'b1; if_pc = pc; if_req = 1'b1;
        repeat (clr_at) begin @(posedge clk_in); @(negedge clk_in); end
        chk("miss_pending_at_clear", {63'd0, instr_signal}, 64'd1);
        if (clr_at == 11) chk("done_with_clear", {63'd0, instr_done}, 64'd1);
        clear_signal = 1'b1; if_req = 1'b0; req_live = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        chk("clear_drops_fill", {63'd0, instr_signal}, 64'd0);
        clear_signal = 1'b0;
        seen_ready = 0;
        repeat (14) begin
            @(posedge clk_in); @(negedge clk_in);
            if (if_ready) seen_ready = 1;
        end
        chk("no_ready_after_clear", {63'd0, seen_ready}, 64'd0);
    endtask

    int          lat;
    logic [31:0] w, a;

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; if_req = 1'b0; if_pc = '0;
        mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h00; mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
        mem[32'h1004] = 8'h93; mem[32'h1005] = 8'h00; mem[32'h1006] = 8'h10; mem[32'h1007] = 8'h00;
        repeat (3) @(negedge clk_in);
        chk("reset_if_ready", {63'd0, if_ready}, 64'd0);
        chk("reset_if_instr", {32'd0, if_instr}, 64'd0);
        chk("reset_instr_signal", {63'd0, instr_signal}, 64'd0);
        chk("reset_instr_a", {32'd0, instr_a}, 64'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // cold miss and same-line hit
        do_fetch(32'h1000, -1, lat, w, a);
        chk("cold_miss_addr", {32'd0, a}, 64'h1000);
        chk("cold_miss_latency", 64'(lat), 64'd12);
        chk("cold_miss_word", {32'd0, w}, 64'h0000_0013);
        do_fetch(32'h1004, -1, lat, w, a);
        chk("hit_latency", 64'(lat), 64'd1);
        chk("hit_word", {32'd0, w}, 64'h0010_0093);

        // conflict eviction at the same index
        do_fetch(32'h1200, -1, lat, w, a);
        chk("conflict_latency", 64'(lat), 64'd12);
        do_fetch(32'h1000, -1, lat, w, a);
        chk("evicted_latency", 64'(lat), 64'd12);
        chk("evicted_word", {32'd0, w}, 64'h0000_0013);

        // clear mid-miss, then full re-miss
        fetch_clear(32'h1100, 4);
        do_fetch(32'h1100, -1, lat, w, a);
        chk("after_clear_latency", 64'(lat), 64'd12);

        // clear coincident with done: line kept, next access hits
        fetch_clear(32'h1304, 11);
        do_fetch(32'h1304, -1, lat, w, a);
        chk("kept_line_latency", 64'(lat), 64'd1);

        // rdy_in stalls during hit and miss
        do_fetch(32'h1304, 0, lat, w, a);
        chk("stalled_hit_latency", 64'(lat), 64'd4);
        do_fetch(32'h1400, 5, lat, w, a);
        chk("stalled_miss_latency", 64'(lat), 64'd15);

        // reset mid-miss, then a stale done in IDLE must not fill
        cur_pc = 32'h1008; req_live = 1'b1; if_pc = 32'h1008; if_req = 1'b1;
        repeat (5) begin @(posedge clk_in); @(negedge clk_in); end
        rst_in = 1'b1; if_req = 1'b0; req_live = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        chk("rst_mid_miss_signal", {63'd0, instr_signal}, 64'd0);
        chk("rst_mid_miss_addr", {32'd0, instr_a}, 64'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        inj_data = line_of(32'h1008); inj_done = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        inj_done = 1'b0;
        chk("stale_done_no_ready", {63'd0, if_ready}, 64'd0);
        do_fetch(32'h1008, -1, lat, w, a);
        chk("stale_done_ignored", 64'(lat), 64'd12);

        // random traffic over a few conflicting lines
        for (int it = 0; it < 200; it++) begin
            logic [31:0] pc;
            int st;
            pc = ({23'd0, 9'($urandom_range(8, 11))} << 9) | (32'($urandom_range(0, 3)) << 3)
                 | (32'($urandom_range(0, 1)) << 2);
            if (!ref_hit(pc) && $urandom_range(0, 5) == 0) begin
                fetch_clear(pc, int'($urandom_range(1, 11)));
            end else begin
                st = -1;
                if ($urandom_range(0, 4) == 0) st = int'($urandom_range(0, ref_hit(pc) ? 0 : 11));
                do_fetch(pc, st, lat, w, a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks + mchecks, errors + merrors);
        $finish;
    end

endmodule
